// File: rtl/dqfpij_sched_pkg.sv
// Shared definitions for the dq forward-pass sequencer: FSM encodings, lane indices, link width.
package dqfpij_sched_pkg;

    localparam int LINK_W = 3;
    localparam int LANES  = 6;

    localparam int LANE_AX = 0;
    localparam int LANE_AY = 1;
    localparam int LANE_AZ = 2;
    localparam int LANE_LX = 3;
    localparam int LANE_LY = 4;
    localparam int LANE_LZ = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_DONE = 3'd5
    } state_t;

    function automatic logic j_legal(input logic [LINK_W-1:0] j, input int num_links);
        return (j != '0) && (int'(j) <= num_links);
    endfunction

endpackage

// File: rtl/dqfpij_sched_if.sv
// Port bundle between the sequencer (slave side) and its environment (master side).
// Optional err_out exists only when DQFP_SCHED_ERR_EN is defined.
interface dqfpij_sched_if #(parameter int WIDTH = 32);
    import dqfpij_sched_pkg::*;

    logic                          start_in;
    logic [LINK_W-1:0]             j_in;
    logic                          busy_out;
    logic                          done_out;
    logic [LINK_W-1:0]             link_out;
    logic [2:0]                    state_reg_out;
    logic                          s1_bool_out;
    logic                          s2_bool_out;
    logic                          s3_bool_out;
    logic                          mcross_out;
    logic [LANES-1:0][WIDTH-1:0]   dvdq_curr_vec_in;
    logic [LANES-1:0][WIDTH-1:0]   dadq_curr_vec_in;
    logic [LANES-1:0][WIDTH-1:0]   dfdq_curr_vec_in;
    logic [LANES-1:0][WIDTH-1:0]   dvdq_prev_vec_out;
    logic [LANES-1:0][WIDTH-1:0]   dadq_prev_vec_out;
    logic [LANES-1:0][WIDTH-1:0]   dfdq_vec_out;
    logic [LINK_W-1:0]             dfdq_link_out;
    // Result slot handshake: a word transfers on any clock edge where dfdq_valid_out
    // and dfdq_ready_in are both high; while valid is high and ready low, the slot
    // (data and link) is held unchanged. Valid never drops without a transfer.
    logic                          dfdq_valid_out;
    logic                          dfdq_ready_in;
`ifdef DQFP_SCHED_ERR_EN
    logic                          err_out;
`endif

    modport slave (
        input  start_in, j_in, dvdq_curr_vec_in, dadq_curr_vec_in, dfdq_curr_vec_in,
               dfdq_ready_in,
        output busy_out, done_out, link_out, state_reg_out, s1_bool_out, s2_bool_out,
               s3_bool_out, mcross_out, dvdq_prev_vec_out, dadq_prev_vec_out,
               dfdq_vec_out, dfdq_link_out, dfdq_valid_out
`ifdef DQFP_SCHED_ERR_EN
        , output err_out
`endif
    );

    modport master (
        output start_in, j_in, dvdq_curr_vec_in, dadq_curr_vec_in, dfdq_curr_vec_in,
               dfdq_ready_in,
        input  busy_out, done_out, link_out, state_reg_out, s1_bool_out, s2_bool_out,
               s3_bool_out, mcross_out, dvdq_prev_vec_out, dadq_prev_vec_out,
               dfdq_vec_out, dfdq_link_out, dfdq_valid_out
`ifdef DQFP_SCHED_ERR_EN
        , input err_out
`endif
    );

endinterface

// File: rtl/dqfpij_sched_vec6_reg.sv
// Six-lane word register with synchronous reset and load enable.
module dqfp_vec6_reg
    import dqfpij_sched_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [LANES-1:0][WIDTH-1:0] d,
    output logic [LANES-1:0][WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dqfpij_sched.sv
// Sequencer for the dq forward-pass unit: walks links j..NUM_LINKS, feeds back prev vectors,
// streams dfdq per link. Define DQFP_SCHED_ERR_EN to add err_out for illegal start requests.
module dqfpij_sched
    import dqfpij_sched_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16,
    parameter int NUM_LINKS    = 7
) (
    input logic            clk,
    input logic            reset,
    dqfpij_sched_if.slave  bus
);

    if (NUM_LINKS < 1 || NUM_LINKS > 7 || DECIMAL_BITS >= WIDTH) begin : g_bad_params
        $error("dqfpij_sched: illegal parameter set");
    end

    state_t            state_q, state_d;
    logic [LINK_W-1:0] link_q, link_d;
    logic [LINK_W-1:0] j_q;
    logic [LINK_W-1:0] dfdq_link_q;
    logic              valid_q;
    logic              start_ok;
    logic              can_load;
    logic              load;
    logic              done;

    assign start_ok = bus.start_in && j_legal(bus.j_in, NUM_LINKS);
    // The slot may take a new word if it is empty or its current word leaves this cycle.
    assign can_load = !valid_q || bus.dfdq_ready_in;

    always_comb begin
        state_d = state_q;
        link_d  = link_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_S1;
                    link_d  = bus.j_in;
                end
            end
            ST_S1: state_d = ST_S2;
            ST_S2: state_d = ST_S3;
            ST_S3: begin
                if (can_load) begin
                    load = 1'b1;
                    if (int'(link_q) == NUM_LINKS) begin
                        state_d = ST_DONE;
                    end else begin
                        link_d  = link_q + 1'b1;
                        state_d = ST_S1;
                    end
                end
            end
            ST_DONE: begin
                if (can_load) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    link_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                link_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            link_q      <= '0;
            j_q         <= '0;
            valid_q     <= 1'b0;
            dfdq_link_q <= '0;
        end else begin
            state_q <= state_d;
            link_q  <= link_d;
            if (state_q == ST_IDLE && start_ok) begin
                j_q <= bus.j_in;
            end
            if (load) begin
                valid_q     <= 1'b1;
                dfdq_link_q <= link_q;
            end else if (bus.dfdq_ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef DQFP_SCHED_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_IDLE) && bus.start_in && !j_legal(bus.j_in, NUM_LINKS);
        end
    end
    assign bus.err_out = err_q;
`endif

    dqfp_vec6_reg #(.WIDTH(WIDTH)) u_dvdq_prev (
        .clk(clk), .reset(reset), .load(load), .d(bus.dvdq_curr_vec_in), .q(bus.dvdq_prev_vec_out)
    );
    dqfp_vec6_reg #(.WIDTH(WIDTH)) u_dadq_prev (
        .clk(clk), .reset(reset), .load(load), .d(bus.dadq_curr_vec_in), .q(bus.dadq_prev_vec_out)
    );
    dqfp_vec6_reg #(.WIDTH(WIDTH)) u_dfdq_slot (
        .clk(clk), .reset(reset), .load(load), .d(bus.dfdq_curr_vec_in), .q(bus.dfdq_vec_out)
    );

    assign bus.busy_out       = (state_q != ST_IDLE);
    assign bus.done_out       = done;
    assign bus.link_out       = link_q;
    assign bus.state_reg_out  = state_q;
    assign bus.s1_bool_out    = (state_q == ST_S1);
    assign bus.s2_bool_out    = (state_q == ST_S2);
    assign bus.s3_bool_out    = (state_q == ST_S3);
    assign bus.mcross_out     = (state_q == ST_S1 || state_q == ST_S2 || state_q == ST_S3)
                                && (link_q == j_q);
    assign bus.dfdq_link_out  = dfdq_link_q;
    assign bus.dfdq_valid_out = valid_q;

endmodule

// File: tb/tb_dqfpij_sched.sv
// Bench for dqfpij_sched: cycle table for a j=5 run, hand sequences, randomized runs vs queue model.
module tb_dqfpij_sched;
    import dqfpij_sched_pkg::*;

    localparam int W  = 32;
    localparam int NL = 7;

    typedef logic [LANES-1:0][W-1:0] vec_t;

    typedef struct {
        logic       start;
        logic [2:0] j;
        logic       ready;
        logic [2:0] st;
        logic       lk;
        logic [2:0] link;
        logic [2:0] sb;
        logic       mc;
        logic       busy;
        logic       valid;
        logic [2:0] dlink;
        logic       done;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dqfpij_sched_if #(.WIDTH(W)) bus();

    dqfpij_sched #(.WIDTH(W), .DECIMAL_BITS(16), .NUM_LINKS(NL)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    vec_t tbl_dvdq[8];
    vec_t tbl_dadq[8];
    vec_t tbl_dfdq[8];
    vec_t junk;

    // Stand-in for the dq unit: real results only while in S3 for the current link.
    assign bus.dvdq_curr_vec_in = bus.s3_bool_out ? tbl_dvdq[bus.link_out] : junk;
    assign bus.dadq_curr_vec_in = bus.s3_bool_out ? tbl_dadq[bus.link_out] : ~junk;
    assign bus.dfdq_curr_vec_in = bus.s3_bool_out ? tbl_dfdq[bus.link_out] : {junk[2:0], junk[5:3]};

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i] = $urandom;
        return v;
    endfunction

    always @(negedge clk) junk = rand_vec();

    task automatic fill_tables();
        for (int i = 0; i < 8; i++) begin
            tbl_dvdq[i] = rand_vec();
            tbl_dadq[i] = rand_vec();
            tbl_dfdq[i] = rand_vec();
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic row_t mk(input logic start, input logic [2:0] j, input logic ready,
                                input logic [2:0] st, input logic lk, input logic [2:0] link,
                                input logic [2:0] sb, input logic mc, input logic busy,
                                input logic valid, input logic [2:0] dlink, input logic done);
        row_t r;
        r.start = start; r.j = j; r.ready = ready; r.st = st; r.lk = lk; r.link = link;
        r.sb = sb; r.mc = mc; r.busy = busy; r.valid = valid; r.dlink = dlink; r.done = done;
        return r;
    endfunction

    // One run from start to done with a random consumer; expected results come from a queue
    // holding links j..NL in order, data looked up in the stand-in tables.
    task automatic run_random(input logic [2:0] j, input int pct);
        logic [2:0] exp_q[$];
        logic [2:0] l;
        bit         done_seen = 0;
        bit         stall = 0;
        logic [2:0] stall_link = '0;
        vec_t       stall_data = '0;
        int         mc_cnt = 0;
        int         done_c = -1;
        fill_tables();
        for (int i = int'(j); i <= NL; i++) exp_q.push_back(3'(i));
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.j_in = j;
        bus.dfdq_ready_in = ($urandom_range(1, 100) <= pct);
        for (int c = 0; c < 400 && !done_seen; c++) begin
            @(negedge clk);
            bus.start_in = ($urandom_range(0, 3) == 0);
            bus.j_in = 3'($urandom_range(0, 7));
            bus.dfdq_ready_in = ($urandom_range(1, 100) <= pct);
            #1;
            chk("busy during run", bus.busy_out, 1);
            if (bus.mcross_out) mc_cnt++;
            if (stall) begin
                chk("held valid", bus.dfdq_valid_out, 1);
                chk("held link", bus.dfdq_link_out, stall_link);
                chk_vec("held data", bus.dfdq_vec_out, stall_data);
            end
            if (bus.dfdq_valid_out && bus.dfdq_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra result: actual link %0d required none", bus.dfdq_link_out);
                end else begin
                    l = exp_q.pop_front();
                    chk("result link", bus.dfdq_link_out, l);
                    chk_vec("result dfdq", bus.dfdq_vec_out, tbl_dfdq[l]);
                    chk_vec("prev dvdq", bus.dvdq_prev_vec_out, tbl_dvdq[l]);
                    chk_vec("prev dadq", bus.dadq_prev_vec_out, tbl_dadq[l]);
                end
            end
            stall = bus.dfdq_valid_out && !bus.dfdq_ready_in;
            stall_link = bus.dfdq_link_out;
            stall_data = bus.dfdq_vec_out;
            if (bus.done_out) begin
                done_seen = 1;
                done_c = c;
                chk("results left at done", exp_q.size(), 0);
            end
        end
        bus.start_in = 1'b0;
        chk("done seen", done_seen, 1);
        if (pct == 100) begin
            chk("mcross cycles", mc_cnt, 3);
            chk("run length", done_c, 3 * (NL - int'(j) + 1));
        end
        @(negedge clk);
        #1;
        chk("idle after done", bus.busy_out, 0);
        chk("no done in idle", bus.done_out, 0);
    endtask

    row_t rows[12];

    initial begin
        int   n;
        int   hs;
        bit   found;
        logic [2:0] nxt;

        bus.start_in = 1'b0;
        bus.j_in = '0;
        bus.dfdq_ready_in = 1'b0;
        fill_tables();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset state", bus.state_reg_out, 0);
        chk("reset busy", bus.busy_out, 0);
        chk("reset link", bus.link_out, 0);
        chk("reset valid", bus.dfdq_valid_out, 0);
        chk("reset done", bus.done_out, 0);
        chk_vec("reset dvdq prev", bus.dvdq_prev_vec_out, '0);
        chk_vec("reset dfdq slot", bus.dfdq_vec_out, '0);

        // Cycle table: j=5, always ready, one ignored start while busy
        rows[0]  = mk(1, 5, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0);
        rows[1]  = mk(0, 0, 1, 1, 1, 5, 3'b001, 1, 1, 0, 0, 0);
        rows[2]  = mk(0, 0, 1, 2, 1, 5, 3'b010, 1, 1, 0, 0, 0);
        rows[3]  = mk(0, 0, 1, 3, 1, 5, 3'b100, 1, 1, 0, 0, 0);
        rows[4]  = mk(0, 0, 1, 1, 1, 6, 3'b001, 0, 1, 1, 5, 0);
        rows[5]  = mk(1, 1, 1, 2, 1, 6, 3'b010, 0, 1, 0, 5, 0);
        rows[6]  = mk(0, 0, 1, 3, 1, 6, 3'b100, 0, 1, 0, 5, 0);
        rows[7]  = mk(0, 0, 1, 1, 1, 7, 3'b001, 0, 1, 1, 6, 0);
        rows[8]  = mk(0, 0, 1, 2, 1, 7, 3'b010, 0, 1, 0, 6, 0);
        rows[9]  = mk(0, 0, 1, 3, 1, 7, 3'b100, 0, 1, 0, 6, 0);
        rows[10] = mk(0, 0, 1, 5, 0, 7, 3'b000, 0, 1, 1, 7, 1);
        rows[11] = mk(0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 7, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.start_in = rows[k].start;
            bus.j_in = rows[k].j;
            bus.dfdq_ready_in = rows[k].ready;
            #1;
            chk($sformatf("row%0d state", k), bus.state_reg_out, rows[k].st);
            if (rows[k].lk) chk($sformatf("row%0d link", k), bus.link_out, rows[k].link);
            chk($sformatf("row%0d stage", k),
                {bus.s3_bool_out, bus.s2_bool_out, bus.s1_bool_out}, rows[k].sb);
            chk($sformatf("row%0d mcross", k), bus.mcross_out, rows[k].mc);
            chk($sformatf("row%0d busy", k), bus.busy_out, rows[k].busy);
            chk($sformatf("row%0d valid", k), bus.dfdq_valid_out, rows[k].valid);
            chk($sformatf("row%0d dlink", k), bus.dfdq_link_out, rows[k].dlink);
            chk($sformatf("row%0d done", k), bus.done_out, rows[k].done);
            if (rows[k].valid)
                chk_vec($sformatf("row%0d dfdq", k), bus.dfdq_vec_out, tbl_dfdq[rows[k].dlink]);
        end
        bus.start_in = 1'b0;

        // j=2 with consumer stalled after first result; feedback of link-2 dvdq into link 3
        fill_tables();
        tbl_dvdq[2][LANE_AX] = 32'h0001_0000;
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.j_in = 3'd2;
        bus.dfdq_ready_in = 1'b0;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            #1;
            if (bus.dfdq_valid_out) begin
                n = c;
                break;
            end
        end
        chk("first valid latency", n, 4);
        chk("first result link", bus.dfdq_link_out, 2);
        chk("link3 S1 prev AX", bus.dvdq_prev_vec_out[LANE_AX], 32'h0001_0000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (k >= 1) begin
                chk("stall state", bus.state_reg_out, 3);
                chk("stall link", bus.link_out, 3);
                chk("stall s3", bus.s3_bool_out, 1);
            end
            chk("stall slot link", bus.dfdq_link_out, 2);
            chk_vec("stall slot data", bus.dfdq_vec_out, tbl_dfdq[2]);
            chk("stall prev AX", bus.dvdq_prev_vec_out[LANE_AX], 32'h0001_0000);
        end
        hs = 0;
        nxt = 3'd2;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            bus.dfdq_ready_in = 1'b1;
            #1;
            if (bus.dfdq_valid_out) begin
                chk("drain link", bus.dfdq_link_out, nxt);
                chk_vec("drain data", bus.dfdq_vec_out, tbl_dfdq[nxt]);
                nxt = nxt + 3'd1;
                hs++;
            end
            if (bus.done_out) found = 1;
        end
        chk("stall run done", found, 1);
        chk("stall run results", hs, 6);

        // Reset in S2 of link 4, then a fresh start
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.j_in = 3'd1;
        bus.dfdq_ready_in = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            #1;
            if (bus.state_reg_out == 3'd2 && bus.link_out == 3'd4) begin
                found = 1;
                break;
            end
        end
        chk("reached link4 S2", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid reset state", bus.state_reg_out, 0);
        chk("mid reset busy", bus.busy_out, 0);
        chk("mid reset link", bus.link_out, 0);
        chk("mid reset stage", {bus.s3_bool_out, bus.s2_bool_out, bus.s1_bool_out}, 0);
        chk("mid reset mcross", bus.mcross_out, 0);
        chk("mid reset valid", bus.dfdq_valid_out, 0);
        chk("mid reset dlink", bus.dfdq_link_out, 0);
        chk("mid reset done", bus.done_out, 0);
        chk_vec("mid reset dvdq prev", bus.dvdq_prev_vec_out, '0);
        chk_vec("mid reset dadq prev", bus.dadq_prev_vec_out, '0);
        chk_vec("mid reset dfdq slot", bus.dfdq_vec_out, '0);
        run_random(3'd6, 100);

        // Illegal start j=0
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.j_in = 3'd0;
        n = 0;
        found = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            #1;
            if (bus.busy_out || bus.dfdq_valid_out || bus.done_out) found = 1;
`ifdef DQFP_SCHED_ERR_EN
            if (bus.err_out) n++;
`endif
        end
        chk("j0 start activity", found, 0);
`ifdef DQFP_SCHED_ERR_EN
        chk("j0 err pulses", n, 1);
`endif

        // Boundaries and randomized runs
        run_random(3'd1, 100);
        run_random(3'(NL), 100);
        for (int r = 0; r < 16; r++) begin
            run_random(3'($urandom_range(1, NL)), $urandom_range(30, 100));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
